// File: rtl/dct8_chen_ts.sv
// -----------------------------------------------------------------------------
// dct8_chen_ts
// 8-point forward DCT using Chen's even/odd factorisation. The design is a
// three-stage pipeline:
//   stage 1: butterfly      s_n = x[n]+x[7-n], d_n = x[n]-x[7-n]
//   stage 2: constant multiplies (even part folded, odd part 4x4 matrix)
//   stage 3: product sums, round-half-up, arithmetic shift by FRAC, saturate
// One vector is accepted per cycle. Each stage's data registers load only when
// that stage's incoming valid is set, so y holds the last result while idle.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous reset, ACTIVE-HIGH despite the name
//   valid_in   : x carries a vector this cycle
//   x[7:0]     : signed input samples, DATA_W bits each
//   valid_out  : y carries a new coefficient vector this cycle (one-cycle pulse)
//   y[7:0]     : signed DCT coefficients, DATA_W bits each
// -----------------------------------------------------------------------------
module dct8_chen_ts #(
    parameter int DATA_W  = 16,
    parameter int CONST_W = 16,
    parameter int FRAC    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] x [7:0],
    output logic              valid_out,
    output logic [DATA_W-1:0] y [7:0]
);

    // Butterfly width and full-precision accumulation width
    localparam int BW = DATA_W + 1;
    localparam int AW = DATA_W + CONST_W + 4;

    // cos(k*pi/16), k = 1..7
    localparam real COS1 = 0.9807852804032304;
    localparam real COS2 = 0.9238795325112867;
    localparam real COS3 = 0.8314696123025452;
    localparam real COS4 = 0.7071067811865476;
    localparam real COS5 = 0.5555702330196022;
    localparam real COS6 = 0.3826834323650898;
    localparam real COS7 = 0.1950903220161283;
    localparam real SCALE = 0.5 * real'(1 << FRAC);

    // Round to nearest (all values are positive, so +0.5 then truncate)
    localparam int C1_I = $rtoi(COS1 * SCALE + 0.5);
    localparam int C2_I = $rtoi(COS2 * SCALE + 0.5);
    localparam int C3_I = $rtoi(COS3 * SCALE + 0.5);
    localparam int C4_I = $rtoi(COS4 * SCALE + 0.5);
    localparam int C5_I = $rtoi(COS5 * SCALE + 0.5);
    localparam int C6_I = $rtoi(COS6 * SCALE + 0.5);
    localparam int C7_I = $rtoi(COS7 * SCALE + 0.5);

    localparam logic signed [CONST_W-1:0] C1 = CONST_W'(C1_I);
    localparam logic signed [CONST_W-1:0] C2 = CONST_W'(C2_I);
    localparam logic signed [CONST_W-1:0] C3 = CONST_W'(C3_I);
    localparam logic signed [CONST_W-1:0] C4 = CONST_W'(C4_I);
    localparam logic signed [CONST_W-1:0] C5 = CONST_W'(C5_I);
    localparam logic signed [CONST_W-1:0] C6 = CONST_W'(C6_I);
    localparam logic signed [CONST_W-1:0] C7 = CONST_W'(C7_I);

    // Constants sign-extended to the accumulation width
    localparam logic signed [AW-1:0] K1 = AW'(C1);
    localparam logic signed [AW-1:0] K2 = AW'(C2);
    localparam logic signed [AW-1:0] K3 = AW'(C3);
    localparam logic signed [AW-1:0] K4 = AW'(C4);
    localparam logic signed [AW-1:0] K5 = AW'(C5);
    localparam logic signed [AW-1:0] K6 = AW'(C6);
    localparam logic signed [AW-1:0] K7 = AW'(C7);

    // Rounding offset 2^(FRAC-1) and saturation limits at the accumulation width
    localparam logic signed [AW-1:0] RND    = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [AW-1:0] SAT_HI = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_LO = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // A constant must hold a value just under 2^(FRAC-1) plus its sign bit
    if (CONST_W < FRAC + 2) begin : g_const_w_check
        $error("dct8_chen_ts: CONST_W must be at least FRAC+2");
    end

    // Round half up, shift out the fraction, clamp to the output range
    function automatic logic [DATA_W-1:0] sat_round(input logic signed [AW-1:0] p);
        logic signed [AW-1:0] t;
        t = (p + RND) >>> FRAC;
        if (t > SAT_HI) begin
            sat_round = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (t < SAT_LO) begin
            sat_round = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat_round = t[DATA_W-1:0];
        end
    endfunction

    // ---------------- pipeline state ----------------
    logic                     r_v1;
    logic                     r_v2;
    logic                     r_v3;
    logic signed [BW-1:0]     r_s [4];
    logic signed [BW-1:0]     r_d [4];
    logic signed [AW-1:0]     r_pe [6];       // even-part products
    logic signed [AW-1:0]     r_po [4][4];    // odd-part products: [C1,C3,C5,C7][d0..d3]
    logic        [DATA_W-1:0] r_y [7:0];

    logic signed [BW-1:0]     w_s [4];
    logic signed [BW-1:0]     w_d [4];
    logic signed [AW-1:0]     w_pe [6];
    logic signed [AW-1:0]     w_po [4][4];
    logic signed [AW-1:0]     w_p [8];

    // Butterfly: one extra bit keeps the sum/difference exact
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            w_s[n] = BW'($signed(x[n])) + BW'($signed(x[7-n]));
            w_d[n] = BW'($signed(x[n])) - BW'($signed(x[7-n]));
        end
    end

    // Stage 1 registers: valid bit always shifts, data loads only on valid_in
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_v1 <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                r_s[n] <= '0;
                r_d[n] <= '0;
            end
        end else begin
            r_v1 <= valid_in;
            if (valid_in) begin
                for (int n = 0; n < 4; n++) begin
                    r_s[n] <= w_s[n];
                    r_d[n] <= w_d[n];
                end
            end
        end
    end

    // Multiply: the even half folds s into sum/difference pairs first
    always_comb begin
        w_pe[0] = K4 * ((AW'(r_s[0]) + AW'(r_s[3])) + (AW'(r_s[1]) + AW'(r_s[2])));
        w_pe[1] = K4 * ((AW'(r_s[0]) + AW'(r_s[3])) - (AW'(r_s[1]) + AW'(r_s[2])));
        w_pe[2] = K2 * (AW'(r_s[0]) - AW'(r_s[3]));
        w_pe[3] = K6 * (AW'(r_s[1]) - AW'(r_s[2]));
        w_pe[4] = K6 * (AW'(r_s[0]) - AW'(r_s[3]));
        w_pe[5] = K2 * (AW'(r_s[1]) - AW'(r_s[2]));
        for (int j = 0; j < 4; j++) begin
            w_po[0][j] = K1 * AW'(r_d[j]);
            w_po[1][j] = K3 * AW'(r_d[j]);
            w_po[2][j] = K5 * AW'(r_d[j]);
            w_po[3][j] = K7 * AW'(r_d[j]);
        end
    end

    // Stage 2 registers: products load when the butterfly stage held valid data
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_v2 <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                r_pe[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    r_po[i][j] <= '0;
                end
            end
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_pe <= w_pe;
                r_po <= w_po;
            end
        end
    end

    // Sum products into the eight unscaled coefficients
    always_comb begin
        w_p[0] = r_pe[0];
        w_p[4] = r_pe[1];
        w_p[2] = r_pe[2] + r_pe[3];
        w_p[6] = r_pe[4] - r_pe[5];
        w_p[1] = r_po[0][0] + r_po[1][1] + r_po[2][2] + r_po[3][3];
        w_p[3] = r_po[1][0] - r_po[3][1] - r_po[0][2] - r_po[2][3];
        w_p[5] = r_po[2][0] - r_po[0][1] + r_po[3][2] + r_po[1][3];
        w_p[7] = r_po[3][0] - r_po[2][1] + r_po[1][2] - r_po[0][3];
    end

    // Stage 3 registers: outputs update only on a valid product set, else hold
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_v3 <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                r_y[k] <= '0;
            end
        end else begin
            r_v3 <= r_v2;
            if (r_v2) begin
                for (int k = 0; k < 8; k++) begin
                    r_y[k] <= sat_round(w_p[k]);
                end
            end
        end
    end

    assign valid_out = r_v3;
    assign y         = r_y;

endmodule

// File: tb/tb_dct8_chen_ts.sv
// -----------------------------------------------------------------------------
// tb_dct8_chen_ts
// Directed bench for dct8_chen_ts. Every driven vector pushes its expected
// coefficients and due cycle onto a scoreboard; each cycle the output is
// compared either against the due entry or against the held previous result.
// Expected values come from literal vectors or from a direct cosine-matrix
// model (not the Chen factorisation used by the design).
// -----------------------------------------------------------------------------
module tb_dct8_chen_ts;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [15:0] x_s [7:0];
    logic        valid_out;
    logic [15:0] y_s [7:0];

    dct8_chen_ts #(
        .DATA_W (16),
        .CONST_W(16),
        .FRAC   (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .x        (x_s),
        .valid_out(valid_out),
        .y        (y_s)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [127:0] q_y [$];
    int           q_due [$];
    logic [127:0] last_y = 128'd0;

    // round(128*cos(m*pi/16)) for m = 1..7; index 0 is the DC scale (C4), index 8 is cos(pi/2)
    int ctab [0:8] = '{91, 126, 118, 106, 91, 71, 49, 25, 0};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, $signed(obs), $signed(exp), cyc);
        end
    endtask

    function automatic logic [127:0] mk(input int v0, input int v1, input int v2, input int v3,
                                        input int v4, input int v5, input int v6, input int v7);
        logic [127:0] r;
        r = {v7[15:0], v6[15:0], v5[15:0], v4[15:0], v3[15:0], v2[15:0], v1[15:0], v0[15:0]};
        return r;
    endfunction

    // Direct form: P_k = sum_n c(k,n) * x[n], c from cos(k(2n+1)pi/16) folded into the table
    function automatic logic [127:0] model();
        logic [127:0] r;
        longint p;
        longint t;
        int a;
        r = 128'd0;
        for (int k = 0; k < 8; k++) begin
            p = 64'sd0;
            for (int n = 0; n < 8; n++) begin
                a = (k * (2 * n + 1)) % 32;
                if (a > 16) a = 32 - a;
                if (a <= 8) p = p + longint'(ctab[a]) * longint'($signed(x_s[n]));
                else        p = p - longint'(ctab[16 - a]) * longint'($signed(x_s[n]));
            end
            t = (p + 64'sd128) >>> 8;
            if (t > 64'sd32767)       t = 64'sd32767;
            else if (t < -64'sd32768) t = -64'sd32768;
            r[16*k +: 16] = t[15:0];
        end
        return r;
    endfunction

    task automatic check_out();
        logic [127:0] e;
        logic         ev;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            e  = q_y.pop_front();
            void'(q_due.pop_front());
            ev = 1'b1;
            last_y = e;
        end else begin
            e  = last_y;
            ev = 1'b0;
        end
        chk("valid_out", {15'd0, valid_out}, {15'd0, ev});
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("y[%0d]", k), y_s[k], e[16*k +: 16]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        check_out();
    endtask

    task automatic send(input logic [127:0] exp_y);
        valid_in = 1'b1;
        q_y.push_back(exp_y);
        q_due.push_back(cyc + 3);
        tick();
        valid_in = 1'b0;
    endtask

    task automatic set_all(input logic [15:0] v);
        for (int n = 0; n < 8; n++) x_s[n] = v;
    endtask

    task automatic set_rand();
        for (int n = 0; n < 8; n++) x_s[n] = 16'($urandom);
    endtask

    task automatic set_impulse();
        set_all(16'd0);
        x_s[0] = 16'd256;
    endtask

    initial begin
        rst_n    = 1'b1;
        valid_in = 1'b0;
        set_all(16'd0);

        // Reset state
        tick();
        tick();

        // DC, sampled on the first edge after reset release
        rst_n = 1'b0;
        set_all(16'd100);
        send(mk(284, 0, 0, 0, 0, 0, 0, 0));
        repeat (4) tick();

        // Impulse
        set_impulse();
        send(mk(91, 126, 118, 106, 91, 71, 49, 25));
        repeat (4) tick();

        // Positive and negative saturation
        set_all(16'h7FFF);
        send(mk(32767, 0, 0, 0, 0, 0, 0, 0));
        repeat (4) tick();
        set_all(16'h8000);
        send(mk(-32768, 0, 0, 0, 0, 0, 0, 0));
        repeat (4) tick();

        // Streaming: five back-to-back vectors
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) begin
                set_all(16'd100);
                send(mk(284, 0, 0, 0, 0, 0, 0, 0));
            end else begin
                set_impulse();
                send(mk(91, 126, 118, 106, 91, 71, 49, 25));
            end
        end
        repeat (4) tick();

        // Gating: x toggles while valid_in is low, y must hold
        set_rand();
        send(model());
        for (int i = 0; i < 8; i++) begin
            set_rand();
            tick();
        end

        // Reset with two vectors in flight
        set_rand();
        send(model());
        set_rand();
        send(model());
        rst_n = 1'b1;
        #1;
        chk("rst_valid_out", {15'd0, valid_out}, 16'd0);
        for (int k = 0; k < 8; k++) chk($sformatf("rst_y[%0d]", k), y_s[k], 16'd0);
        q_y.delete();
        q_due.delete();
        last_y = 128'd0;
        tick();
        tick();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_rand();
            tick();
        end
        set_rand();
        send(model());
        repeat (4) tick();

        // Random stream with random valid gaps
        for (int i = 0; i < 16; i++) begin
            set_rand();
            if ($urandom_range(1, 0) == 1) send(model());
            else tick();
        end
        repeat (4) tick();

        chk("scoreboard_empty", 16'(q_due.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dct8_chen_ts.md
DCT8_CHEN_TS -- requirements
Module: dct8_chen_ts

Interface
REQ-001 Parameter DATA_W, default 16: signed two's-complement width of each input and output sample.
REQ-002 Parameter CONST_W, default 16: signed width of each cosine constant; CONST_W >= FRAC+2 SHALL hold, else elaboration error.
REQ-003 Parameter FRAC, default 8: fraction bits of the cosine constants and right-shift amount of the final product sums.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-high (asserted when 1), despite the _n suffix.
REQ-006 valid_in  input  1  x holds a valid 8-sample vector this cycle.
REQ-007 x  input  [DATA_W-1:0] x[7:0]  unpacked array of signed input samples x[0]..x[7].
REQ-008 valid_out  output  1  y holds a new valid coefficient vector this cycle.
REQ-009 y  output  [DATA_W-1:0] y[7:0]  unpacked array of signed DCT coefficients y[0]..y[7].

Function
REQ-010 Constants SHALL be Ck = round(2^FRAC * 0.5*cos(k*pi/16)), k=1..7, elaboration-time; for FRAC=8: C1=126, C2=118, C3=106, C4=91, C5=71, C6=49, C7=25.
REQ-011 Butterfly stage SHALL compute, exactly (no truncation), s_n = x[n]+x[7-n] and d_n = x[n]-x[7-n], n=0..3.
REQ-012 Even outputs: P0 = C4*((s0+s3)+(s1+s2)); P4 = C4*((s0+s3)-(s1+s2)); P2 = C2*(s0-s3)+C6*(s1-s2); P6 = C6*(s0-s3)-C2*(s1-s2).
REQ-013 Odd outputs: P1 = C1d0+C3d1+C5d2+C7d3; P3 = C3d0-C7d1-C1d2-C5d3; P5 = C5d0-C1d1+C7d2+C3d3; P7 = C7d0-C5d1+C3d2-C1d3.
REQ-014 All products and sums SHALL be carried at full precision, at least DATA_W+CONST_W+4 bits signed; no intermediate rounding.
REQ-015 y[k] = saturate_DATA_W((Pk + 2^(FRAC-1)) >>> FRAC), arithmetic shift; saturation clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-016 Pipeline SHALL be 3 register stages: butterfly, multiply, sum/round/saturate; latency exactly 3 cycles from valid_in sample edge to valid_out high.
REQ-017 Throughput one vector per cycle; back-to-back valid_in vectors produce back-to-back valid_out with no bubbles and no stall input.
REQ-018 valid SHALL propagate through a 3-deep shift register; each stage's data registers load only when that stage's incoming valid is 1, otherwise hold.
REQ-019 y SHALL hold the last valid result while valid_out is 0; valid_out is high for exactly one cycle per accepted vector.
REQ-020 x values while valid_in=0 SHALL have no effect on any output.

Reset
REQ-021 While rst_n=1: all valid pipeline bits, valid_out and every y[k] SHALL be 0 immediately (asynchronous).
REQ-022 Vectors in flight at reset assertion SHALL be discarded; no valid_out for them after release.
REQ-023 First vector sampled on the first rising edge after rst_n falls SHALL appear 3 cycles later.

Verification
REQ-024 DC: x[all]=100, one valid_in pulse -> 3 cycles later valid_out=1, y[0]=284, y[1..7]=0.
REQ-025 Impulse: x[0]=256, others 0 -> y = {91,126,118,106,91,71,49,25} for y[0..7].
REQ-026 Saturation: x[all]=32767 -> y[0]=32767; x[all]=-32768 -> y[0]=-32768; y[1..7]=0 in both cases.
REQ-027 Streaming: 5 consecutive valid vectors (DC, impulse, DC, ...) -> 5 consecutive valid_out cycles, results in order, each 3 cycles after its input.
REQ-028 Reset mid-stream: assert rst_n with 2 vectors in flight -> valid_out and y go 0 at once; no valid_out after release until a new valid_in + 3 cycles.
REQ-029 Gating: toggle x randomly with valid_in=0 after a valid vector -> y holds that vector's result, valid_out stays 0.
